// File: rtl/uart_native_responder.sv
// uart_native_responder: native valid/ready register slave with 8N1 UART TX/RX engines.
// Define UART_RTS_CTS_EN to add the cts input / rts output flow-control pins.
module uart_native_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 3,
    parameter logic [15:0] DIV_RST = 16'd100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                txd,
    input  logic                rxd
`ifdef UART_RTS_CTS_EN
    ,
    input  logic                cts,
    output logic                rts
`endif
);

    localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(7);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // Bus request and write pipeline
    logic              accept;
    logic              is_wr;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [DATA_W-1:0] rd_val;
    logic              unused_wdata;

    // Control / status registers
    logic [15:0] div_q;
    logic        tx_en;
    logic        rx_en;
    logic        rx_valid;
    logic [7:0]  rx_buf;
    logic [15:0] period;
    logic [15:0] half;
    logic        soft_rst;
    logic        tx_load;
    logic        tx_ready;
    logic        rx_read;
    logic        cts_ok;

    // TX engine
    uart_state_e tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        txd_n;
    logic        tx_end;

    // RX engine
    uart_state_e rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_fall;
    logic        rx_end;
    logic        rx_done;

    assign accept       = valid & ~ready;
    assign is_wr        = |wstrb;
    assign unused_wdata = ^wdata[DATA_W-1:16];

    assign period  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign half    = period >> 1;
    assign tx_end  = tx_cnt >= (period - 16'd1);
    assign rx_end  = rx_cnt >= (period - 16'd1);
    assign rx_fall = rx_prev & ~rx_s2;

    // Writes take effect on the edge that closes their ready cycle
    assign soft_rst = wr_pend && (wr_addr == A_SOFTRESET) && wr_data[0];
    assign tx_load  = wr_pend && (wr_addr == A_TXDATA) && tx_ready;
    assign tx_ready = tx_en && (tx_state == S_IDLE) && cts_ok;
    assign rx_read  = accept && !is_wr && (addr == A_RXDATA);

`ifdef UART_RTS_CTS_EN
    logic cts_s1, cts_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_s1 <= 1'b0;
            cts_s2 <= 1'b0;
        end else begin
            cts_s1 <= cts;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok = cts_s2;
    assign rts    = rx_en & ~rx_valid;
`else
    assign cts_ok = 1'b1;
`endif

    // Read mux: write-only addresses and all writes return zero
    always_comb begin
        rd_val = '0;
        if (!is_wr) begin
            case (addr)
                A_TXREADY: rd_val = DATA_W'(tx_ready);
                A_RXREADY: rd_val = DATA_W'(rx_valid);
                A_RXDATA:  rd_val = DATA_W'(rx_buf);
                default:   rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready   <= 1'b0;
            rdata   <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            ready   <= accept;
            rdata   <= accept ? rd_val : '0;
            wr_pend <= accept & is_wr;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= wdata[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= DIV_RST;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            rx_valid <= 1'b0;
            rx_buf   <= 8'h00;
        end else begin
            if (soft_rst) begin
                tx_en <= 1'b0;
                rx_en <= 1'b0;
            end else if (wr_pend) begin
                case (wr_addr)
                    A_DIV:   div_q <= wr_data;
                    A_TXEN:  tx_en <= wr_data[0];
                    A_RXEN:  rx_en <= wr_data[0];
                    default: ;
                endcase
            end
            // A completing byte beats a same-cycle RXDATA read
            if (soft_rst) begin
                rx_valid <= 1'b0;
            end else if (rx_done) begin
                rx_valid <= 1'b1;
                rx_buf   <= rx_shift;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        if (soft_rst) begin
            tx_state_n = S_IDLE;
            tx_cnt_n   = 16'd0;
            tx_bit_n   = 3'd0;
            txd_n      = 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    txd_n = 1'b1;
                    if (tx_load) begin
                        tx_state_n = S_START;
                        tx_shift_n = wr_data[7:0];
                        tx_cnt_n   = 16'd0;
                        txd_n      = 1'b0;
                    end
                end
                S_START: begin
                    tx_cnt_n = tx_cnt + 16'd1;
                    if (tx_end) begin
                        tx_state_n = S_DATA;
                        tx_cnt_n   = 16'd0;
                        tx_bit_n   = 3'd0;
                        txd_n      = tx_shift[0];
                    end
                end
                S_DATA: begin
                    tx_cnt_n = tx_cnt + 16'd1;
                    if (tx_end) begin
                        tx_cnt_n = 16'd0;
                        if (tx_bit == 3'd7) begin
                            tx_state_n = S_STOP;
                            txd_n      = 1'b1;
                        end else begin
                            tx_bit_n   = tx_bit + 3'd1;
                            tx_shift_n = {1'b0, tx_shift[7:1]};
                            txd_n      = tx_shift[1];
                        end
                    end
                end
                S_STOP: begin
                    tx_cnt_n = tx_cnt + 16'd1;
                    if (tx_end) begin
                        tx_state_n = S_IDLE;
                        tx_cnt_n   = 16'd0;
                    end
                end
                default: tx_state_n = S_IDLE;
            endcase
        end
    end

    // rxd is asynchronous: two-flop synchronizer plus edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        if (soft_rst) begin
            rx_state_n = S_IDLE;
            rx_cnt_n   = 16'd0;
            rx_bit_n   = 3'd0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_en && rx_fall) begin
                        rx_state_n = S_START;
                        rx_cnt_n   = 16'd0;
                    end
                end
                S_START: begin
                    rx_cnt_n = rx_cnt + 16'd1;
                    if (rx_cnt >= half) begin
                        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                        rx_cnt_n   = 16'd0;
                        rx_bit_n   = 3'd0;
                    end
                end
                S_DATA: begin
                    rx_cnt_n = rx_cnt + 16'd1;
                    if (rx_end) begin
                        rx_cnt_n   = 16'd0;
                        rx_shift_n = {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state_n = S_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    rx_cnt_n = rx_cnt + 16'd1;
                    if (rx_end) begin
                        rx_state_n = S_IDLE;
                        rx_cnt_n   = 16'd0;
                        rx_done    = rx_s2;
                    end
                end
                default: rx_state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_native_responder.sv
// tb_uart_native_responder: directed self-checking bench for uart_native_responder.
// Build with UART_RTS_CTS_EN defined to also exercise the cts/rts pins.
module tb_uart_native_responder;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        txd;
    logic        rxd;
`ifdef UART_RTS_CTS_EN
    logic        cts;
    logic        rts;
`endif

    int vectors;
    int miscompares;

    uart_native_responder #(
        .DATA_W (32),
        .ADDR_W (3),
        .DIV_RST(16'd100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .valid(valid),
        .addr (addr),
        .wdata(wdata),
        .wstrb(wstrb),
        .rdata(rdata),
        .ready(ready),
        .txd  (txd),
        .rxd  (rxd)
`ifdef UART_RTS_CTS_EN
        ,
        .cts  (cts),
        .rts  (rts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus request; ready must rise exactly one cycle after valid and drop the next.
    task automatic bus_xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] r);
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(posedge clk); #1;
        valid = 1'b0;
        wstrb = 4'h0;
        chk("ready_ack", 32'(ready), 32'd1);
        r = rdata;
        @(posedge clk); #1;
        chk("ready_drop", 32'(ready), 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(a, d, 4'hF, r);
        chk("wr_rdata", r, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(a, 32'd0, 4'h0, r);
        chk(tag, r, exp);
    endtask

    function automatic logic exp_txd(input logic [7:0] b, input int c);
        int k;
        k = c / 4;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    // Checks txd on every cycle of a DIV=4 frame from cycle c0 through the first idle cycle.
    task automatic check_tx_frame(input logic [7:0] b, input int c0);
        for (int c = c0; c <= 40; c++) begin
            chk("txd_bit", 32'(txd), 32'(exp_txd(b, c)));
            @(posedge clk); #1;
        end
    endtask

    // Drives one 8N1 frame at 8 clk/bit.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (8) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (8) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        valid = 1'b0;
        addr  = 3'd0;
        wdata = 32'd0;
        wstrb = 4'h0;
        rxd   = 1'b1;
`ifdef UART_RTS_CTS_EN
        cts   = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_txd", 32'(txd), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset state of read-only registers, and write-only read-back
        rd_chk("rst_txready", 3'd5, 32'd0);
        rd_chk("rst_rxready", 3'd6, 32'd0);
        rd_chk("rst_rxdata", 3'd7, 32'd0);
        rd_chk("div_read_zero", 3'd1, 32'd0);
        chk("idle_txd", 32'(txd), 32'd1);

        // TX frame 0x55 at DIV=4
        wr(3'd1, 32'd4);
        wr(3'd3, 32'd1);
        wr(3'd5, 32'd0);
        rd_chk("txready_en", 3'd5, 32'd1);
        wr(3'd2, 32'h55);
        check_tx_frame(8'h55, 0);
        rd_chk("txready_after", 3'd5, 32'd1);

        // TX frame 0xF0; second TXDATA write mid-frame is dropped
        wr(3'd2, 32'hF0);
        wr(3'd2, 32'h0F);
        rd_chk("txready_busy", 3'd5, 32'd0);
        check_tx_frame(8'hF0, 4);
        rd_chk("txready_done2", 3'd5, 32'd1);

        // SOFTRESET mid-frame
        wr(3'd2, 32'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("sr_txd_before", 32'(txd), 32'd0);
        wr(3'd0, 32'd1);
        chk("sr_txd_after", 32'(txd), 32'd1);
        rd_chk("sr_txready", 3'd5, 32'd0);
        repeat (50) @(posedge clk);
        #1;
        chk("sr_txd_idle", 32'(txd), 32'd1);
        wr(3'd3, 32'd1);
        rd_chk("sr_txready_en", 3'd5, 32'd1);

`ifdef UART_RTS_CTS_EN
        cts = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("cts_block", 3'd5, 32'd0);
        cts = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("cts_release", 3'd5, 32'd1);
`endif

        // RX at DIV=8
        wr(3'd1, 32'd8);
        wr(3'd4, 32'd1);
        rd_chk("rx_idle_ready", 3'd6, 32'd0);
`ifdef UART_RTS_CTS_EN
        chk("rts_open", 32'(rts), 32'd1);
`endif
        send_rx(8'hA3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("rx_a3_ready", 3'd6, 32'd1);
`ifdef UART_RTS_CTS_EN
        chk("rts_full", 32'(rts), 32'd0);
`endif
        rd_chk("rx_a3_data", 3'd7, 32'hA3);
        rd_chk("rx_a3_clear", 3'd6, 32'd0);
`ifdef UART_RTS_CTS_EN
        chk("rts_reopen", 32'(rts), 32'd1);
`endif

        // Framing error and start-bit glitch
        send_rx(8'h3C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rd_chk("rx_frame_err", 3'd6, 32'd0);
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rd_chk("rx_glitch", 3'd6, 32'd0);
        rd_chk("rx_stale", 3'd7, 32'hA3);

        // Overrun: second byte overwrites
        send_rx(8'h11, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send_rx(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rd_chk("rx_ovr_ready", 3'd6, 32'd1);
        rd_chk("rx_ovr_data", 3'd7, 32'h22);
        rd_chk("rx_ovr_clear", 3'd6, 32'd0);

        // RXDATA read coinciding with byte completion: new byte survives
        fork
            send_rx(8'h5A, 1'b1);
            begin
                repeat (79) @(posedge clk);
                #1;
                rd_chk("rx_race_old", 3'd7, 32'h22);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        rd_chk("rx_race_ready", 3'd6, 32'd1);
        rd_chk("rx_race_data", 3'd7, 32'h5A);

        // Async reset mid-frame
        wr(3'd2, 32'h00);
        chk("ar_txd_low", 32'(txd), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_txd_high", 32'(txd), 32'd1);
        chk("ar_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rd_chk("ar_txready", 3'd5, 32'd0);
        rd_chk("ar_rxready", 3'd6, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
